// File: rtl/pulse_generator.sv
// Turns two active-low push buttons into one-cycle up/down command pulses with
// keyboard-style auto-repeat, input synchronisation and simultaneous-press lockout.
module pulse_generator #(
    parameter int unsigned ClockPeriod_ns     = 20,
    parameter int unsigned PauseInterval_ns   = 25_000,
    parameter int unsigned RepeatsInterval_ns = 15_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iUp,
    input  logic iDown,
    output logic oUp,
    output logic oDown
);

    localparam int unsigned PauseCycles  = PauseInterval_ns / ClockPeriod_ns;
    localparam int unsigned RepeatCycles = RepeatsInterval_ns / ClockPeriod_ns;
    localparam int unsigned MaxCycles    = (PauseCycles > RepeatCycles) ? PauseCycles
                                                                        : RepeatCycles;
    localparam int unsigned CntW         = $clog2(MaxCycles) + 1;

    if (PauseCycles < 2) begin : g_bad_pause
        $error("pulse_generator: PauseCycles must be at least 2");
    end
    if (RepeatCycles < 2) begin : g_bad_repeat
        $error("pulse_generator: RepeatCycles must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StPause, StRepeat, StLock} state_e;

    logic up_meta_q, up_sync_q, down_meta_q, down_sync_q;
    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic dir_up_q, dir_up_d;
    logic up_q, up_d, down_q, down_d;

    logic up_held, down_held, active_held, other_held;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            up_meta_q   <= 1'b1;
            up_sync_q   <= 1'b1;
            down_meta_q <= 1'b1;
            down_sync_q <= 1'b1;
        end else begin
            up_meta_q   <= iUp;
            up_sync_q   <= up_meta_q;
            down_meta_q <= iDown;
            down_sync_q <= down_meta_q;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dir_up_q <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            up_q     <= up_d;
            down_q   <= down_d;
        end
    end

    assign up_held     = ~up_sync_q;
    assign down_held   = ~down_sync_q;
    assign active_held = dir_up_q ? up_held : down_held;
    assign other_held  = dir_up_q ? down_held : up_held;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        up_d     = 1'b0;
        down_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (up_held && down_held) begin
                    state_d = StLock;
                end else if (up_held || down_held) begin
                    dir_up_d = up_held;
                    up_d     = up_held;
                    down_d   = down_held;
                    cnt_d    = CntW'(PauseCycles);
                    state_d  = StPause;
                end
            end
            StPause, StRepeat: begin
                // A second button always wins over release so a chord never leaks a pulse.
                if (other_held) begin
                    state_d = StLock;
                end else if (!active_held) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(1)) begin
                    up_d    = dir_up_q;
                    down_d  = ~dir_up_q;
                    cnt_d   = CntW'(RepeatCycles);
                    state_d = StRepeat;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StLock: begin
                if (!up_held && !down_held) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign oUp   = up_q;
    assign oDown = down_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Directed and randomized checks of pulse_generator against a timeline model that
// derives pulse instants from press start time and the pause/repeat intervals.
module tb_pulse_generator;

    localparam int unsigned PeriodNs = 20;
    localparam int unsigned PauseNs  = 25_000;
    localparam int unsigned RepNs    = 15_000;
    localparam int P = PauseNs / PeriodNs;
    localparam int R = RepNs / PeriodNs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up_n = 1'b1;
    logic dn_n = 1'b1;
    logic o_up, o_dn;

    int total = 0;
    int bad = 0;

    // Model: raw input history (sync delay), phase 0=idle 1=run 2=lock.
    logic h_u1, h_u2, h_d1, h_d2;
    int phase;
    bit run_up;
    int start;
    int cyc = 0;
    logic exp_up, exp_dn;
    int n_up, n_dn;

    always #(PeriodNs / 2) clk = ~clk;

    pulse_generator #(
        .ClockPeriod_ns    (PeriodNs),
        .PauseInterval_ns  (PauseNs),
        .RepeatsInterval_ns(RepNs)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .iUp  (up_n),
        .iDown(dn_n),
        .oUp  (o_up),
        .oDown(o_dn)
    );

    task automatic check(input string tag, input logic got, input logic want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s: got %b want %b at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic count_check(input string tag, input int got, input int want);
        total++;
        assert (got == want)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        h_u1 = 1'b1; h_u2 = 1'b1; h_d1 = 1'b1; h_d2 = 1'b1;
        phase = 0;
        exp_up = 1'b0;
        exp_dn = 1'b0;
    endtask

    task automatic model_edge();
        bit u, d, act, oth;
        int e;
        u = !h_u2;
        d = !h_d2;
        h_u2 = h_u1; h_u1 = up_n;
        h_d2 = h_d1; h_d1 = dn_n;
        exp_up = 1'b0;
        exp_dn = 1'b0;
        if (phase == 0) begin
            if (u && d) phase = 2;
            else if (u || d) begin
                phase = 1; run_up = u; start = cyc;
                exp_up = u; exp_dn = d;
            end
        end else if (phase == 1) begin
            act = run_up ? u : d;
            oth = run_up ? d : u;
            if (oth) phase = 2;
            else if (!act) phase = 0;
            else begin
                e = cyc - start;
                if (e == P || (e > P && (e - P) % R == 0)) begin
                    exp_up = run_up; exp_dn = !run_up;
                end
            end
        end else if (!u && !d) begin
            phase = 0;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check("up", o_up, exp_up);
        check("down", o_dn, exp_dn);
        check("exclusive", o_up & o_dn, 1'b0);
        n_up += int'(o_up);
        n_dn += int'(o_dn);
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        n_up = 0;
        n_dn = 0;
    endtask

    initial begin
        model_reset();
        clr();

        // Reset held with buttons released, then quiet.
        rst = 1'b1;
        hold(10);
        rst = 1'b0;
        hold(20);
        count_check("reset_quiet_up", n_up, 0);
        count_check("reset_quiet_dn", n_dn, 0);

        // Long Up hold: first pulse, pause, then three repeats.
        clr();
        up_n = 1'b0; hold(3750);
        up_n = 1'b1; hold(100);
        count_check("long_up_pulses", n_up, 5);
        count_check("long_up_dn", n_dn, 0);

        // Short Down press: single pulse.
        clr();
        dn_n = 1'b0; hold(1000);
        dn_n = 1'b1; hold(50);
        count_check("short_dn_pulses", n_dn, 1);
        count_check("short_dn_up", n_up, 0);

        // Chord locks out; partial release stays locked.
        clr();
        up_n = 1'b0; dn_n = 1'b0; hold(500);
        up_n = 1'b1; hold(100);
        count_check("lock_up", n_up, 0);
        count_check("lock_dn", n_dn, 0);
        dn_n = 1'b1; hold(10);
        dn_n = 1'b0; hold(20);
        dn_n = 1'b1; hold(10);
        count_check("after_lock_dn", n_dn, 1);

        // Down pressed during Up repeat stops pulses until both released.
        clr();
        up_n = 1'b0; hold(2100);
        dn_n = 1'b0; hold(300);
        dn_n = 1'b1; hold(1600);
        up_n = 1'b1; hold(20);
        count_check("cancel_up", n_up, 3);
        count_check("cancel_dn", n_dn, 0);

        // Reset asserted right on a repeat pulse.
        clr();
        up_n = 1'b0;
        for (int i = 0; i < 3000 && n_up < 2; i++) tick();
        count_check("reach_repeat", n_up, 2);
        rst = 1'b1;
        #1;
        check("reset_async_up", o_up, 1'b0);
        tick();
        rst = 1'b0;
        clr();
        hold(1300);
        count_check("restart_up", n_up, 2);
        up_n = 1'b1; hold(20);

        // Random segments, every cycle checked against the model.
        for (int seg = 0; seg < 16; seg++) begin
            int len;
            up_n = 1'($urandom_range(0, 1));
            dn_n = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                              : int'($urandom_range(10, 2200));
            hold(len);
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        up_n = 1'b1; dn_n = 1'b1;
        hold(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
- Converts two active-low push-button inputs (Up, Down) into single-cycle, active-high command pulses with keyboard-style auto-repeat.
- A press yields one immediate pulse. If the button stays held past a pause interval, pulses repeat at a fixed repeat interval until release.
- Sits between raw board buttons and up/down counter or menu logic.
- Includes input synchronisation and simultaneous-press suppression.

Parameters:
- ClockPeriod_ns, 20: period of Clock in ns. Used only to convert the intervals to cycle counts.
- PauseInterval_ns, 25_000: hold time from the first pulse to the first repeat pulse.
- RepeatsInterval_ns, 15_000: spacing between consecutive repeat pulses.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high reset.
- iUp    input  1  Up button, active-low (1 = released), asynchronous to Clock.
- iDown  input  1  Down button, active-low, asynchronous to Clock.
- oUp    output 1  one-cycle active-high Up pulse.
- oDown  output 1  one-cycle active-high Down pulse.

Behaviour:
- Cycle counts:
  - PauseCycles = PauseInterval_ns / ClockPeriod_ns (integer division). Default 1250.
  - RepeatCycles = RepeatsInterval_ns / ClockPeriod_ns. Default 750.
  - Elaboration error if either count is < 2.
  - Counter width = $clog2(max(PauseCycles, RepeatCycles)) + 1.
- Synchronisation: each input passes through a 2-flop synchroniser. Reset value of both flops is 1 (released). All logic below uses the synchronised levels (sUp, sDown).
- Reset: asynchronous and immediate.
  - oUp = oDown = 0, counter = 0, state = IDLE, synchronisers = 1.
  - Asserting reset mid-sequence aborts it; no pulse is emitted during reset.
- States:
  - IDLE:
    - If exactly one of sUp/sDown is low: emit one pulse on the matching output (next cycle, registered), load the counter with PauseCycles, go to PAUSE.
    - If both are low: go to LOCK, no pulse.
  - PAUSE:
    - Counter decrements each cycle.
    - When it expires while the same button is still held: emit a pulse, load RepeatCycles, go to REPEAT.
  - REPEAT:
    - Counter decrements each cycle.
    - On expiry: emit a pulse and reload RepeatCycles.
  - LOCK: no outputs. Return to IDLE only when both synchronised inputs are high.
- In PAUSE or REPEAT:
  - Release of the active button → IDLE on the next edge; no further pulses.
  - The other button going low → LOCK, no pulse.
- Pulse timing:
  - Each pulse is high for exactly 1 Clock cycle. oUp and oDown are never high together.
  - First pulse rises 3 rising edges after the input is first sampled low (2 synchroniser + 1 output register).
  - Pulse k+1 (k ≥ 1) rises exactly PauseCycles cycles after pulse 1 for k = 1, then every RepeatCycles cycles after that.
- A press shorter than PauseCycles gives exactly one pulse.
- A button already low when reset deasserts counts as a press and produces one pulse.
- Outputs are registered; there is no combinational path from input to output.
- No debouncing beyond synchronisation. Callers provide clean buttons or accept bounce-induced extra pulses.

Test Plan:
- Reset with both inputs high, hold 10 cycles → oUp = oDown = 0 throughout; no pulses after release of Reset.
- Up held 75 µs from t = 50.5 µs (defaults, 20 ns clock) → oUp pulses at ≈50.56, 75.56, 90.56, 105.56, 120.56 µs: exactly 5 pulses, each one cycle wide. None after release; oDown stays 0.
- Down held 20 µs (shorter than the pause) → exactly one oDown pulse, about 3 cycles after the press; no repeat.
- Both pressed together, held 10 µs → no pulse on either output. Release Up only → still no pulses (LOCK). Release both, then press Down → one oDown pulse.
- Up held, Down pressed during REPEAT → pulses stop immediately. Releasing Down while Up remains low produces nothing until both are released.
- Reset asserted mid-REPEAT for 1 cycle with Up still held → outputs drop to 0 at once. After deassertion a fresh sequence starts: pulse, then PauseCycles later the first repeat.
